// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path: FSM state encoding,
// default frame width, parity-type codes and the 2-of-3 vote helper.
package uart_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b000,
        ST_START  = 3'b001,
        ST_DATA   = 3'b011,
        ST_PARITY = 3'b010,
        ST_STOP   = 3'b110,
        ST_BREAK  = 3'b100
    } rx_state_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit-time edge counter and mid-bit 3-sample majority vote for the UART receiver.
// The third sample is the live line value, so the vote resolves at edge PRESCALE/2+1.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESCALE = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    input  logic active,
    input  logic start,
    output logic majority,
    output logic sample_done,
    output logic bit_end
);

    localparam int EW = $clog2(PRESCALE);
    localparam logic [EW-1:0] E_S0   = EW'(PRESCALE / 2 - 1);
    localparam logic [EW-1:0] E_S1   = EW'(PRESCALE / 2);
    localparam logic [EW-1:0] E_S2   = EW'(PRESCALE / 2 + 1);
    localparam logic [EW-1:0] E_LAST = EW'(PRESCALE - 1);
    localparam logic [EW-1:0] E_ONE  = EW'(1);

    logic [EW-1:0] edge_cnt;
    logic          s0;
    logic          s1;

    // Edge counter: free-runs while a frame is active; the start-detect cycle is edge 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt <= '0;
        end else if (active) begin
            edge_cnt <= (edge_cnt == E_LAST) ? '0 : edge_cnt + E_ONE;
        end else if (start) begin
            edge_cnt <= E_ONE;
        end else begin
            edge_cnt <= '0;
        end
    end

    // First two mid-bit samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0 <= 1'b0;
            s1 <= 1'b0;
        end else begin
            if (active && (edge_cnt == E_S0)) begin
                s0 <= rx;
            end
            if (active && (edge_cnt == E_S1)) begin
                s1 <= rx;
            end
        end
    end

    assign majority    = majority3(s0, s1, rx);
    assign sample_done = active && (edge_cnt == E_S2);
    assign bit_end     = active && (edge_cnt == E_LAST);

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive controller: start detect, LSB-first deserialize, optional parity,
// stop check, registered result strobes. Define UART_RX_SYNC_EN to add a 2-flop input synchronizer.
module uart_rx_fsm
    import uart_pkg::*;
#(
    parameter int PRESCALE   = 8,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk_rx,
    input  logic                  rst_rx,
    input  logic                  rx_in_rx,
    input  logic                  par_en_rx,
    input  logic                  par_typ_rx,
    output logic [DATA_WIDTH-1:0] p_data_rx,
    output logic                  data_valid_rx,
    output logic                  par_err_rx,
    output logic                  stp_err_rx,
    output logic                  busy_rx
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);

    rx_state_e             state_r;
    rx_state_e             state_next;
    logic [BW-1:0]         bit_cnt_r;
    logic [DATA_WIDTH-1:0] shift_r;
    logic [DATA_WIDTH-1:0] p_data_r;
    logic                  par_flag_r;
    logic                  par_en_r;
    logic                  par_typ_r;
    logic                  valid_r;
    logic                  par_err_r;
    logic                  stp_err_r;
    logic                  busy_r;

    logic rx_s;
    logic active_s;
    logic start_s;
    logic majority_s;
    logic sample_done_s;
    logic bit_end_s;
    logic valid_next;
    logic par_err_next;
    logic stp_err_next;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_r;

    // Two-stage synchronizer, idle-high so reset does not look like a start bit
    always_ff @(posedge clk_rx or posedge rst_rx) begin
        if (rst_rx) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], rx_in_rx};
        end
    end

    assign rx_s = sync_r[1];
`else
    assign rx_s = rx_in_rx;
`endif

    assign active_s = (state_r == ST_START) || (state_r == ST_DATA) ||
                      (state_r == ST_PARITY) || (state_r == ST_STOP);
    assign start_s  = (state_r == ST_IDLE) && !rx_s;

    uart_rx_sampler #(
        .PRESCALE(PRESCALE)
    ) u_sampler (
        .clk        (clk_rx),
        .rst        (rst_rx),
        .rx         (rx_s),
        .active     (active_s),
        .start      (start_s),
        .majority   (majority_s),
        .sample_done(sample_done_s),
        .bit_end    (bit_end_s)
    );

    // State register
    always_ff @(posedge clk_rx or posedge rst_rx) begin
        if (rst_rx) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    // Next-state and strobe decode; STOP decides mid-bit so a prompt next start is not missed
    always_comb begin
        state_next   = state_r;
        valid_next   = 1'b0;
        par_err_next = 1'b0;
        stp_err_next = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!rx_s) state_next = ST_START;
                else       state_next = ST_IDLE;
            end
            ST_START: begin
                if (sample_done_s && majority_s) state_next = ST_IDLE;
                else if (bit_end_s)              state_next = ST_DATA;
                else                             state_next = ST_START;
            end
            ST_DATA: begin
                if (bit_end_s && (bit_cnt_r == LAST_BIT)) state_next = par_en_r ? ST_PARITY : ST_STOP;
                else                                      state_next = ST_DATA;
            end
            ST_PARITY: begin
                if (bit_end_s) state_next = ST_STOP;
                else           state_next = ST_PARITY;
            end
            ST_STOP: begin
                if (sample_done_s && majority_s) begin
                    state_next   = ST_IDLE;
                    valid_next   = !par_flag_r;
                    par_err_next = par_flag_r;
                end else if (sample_done_s) begin
                    state_next   = ST_BREAK;
                    stp_err_next = 1'b1;
                    par_err_next = par_flag_r;
                end else begin
                    state_next   = ST_STOP;
                end
            end
            ST_BREAK: begin
                if (rx_s) state_next = ST_IDLE;
                else      state_next = ST_BREAK;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: frame config capture, bit counter, shifter, parity check
    always_ff @(posedge clk_rx or posedge rst_rx) begin
        if (rst_rx) begin
            bit_cnt_r  <= '0;
            shift_r    <= '0;
            par_flag_r <= 1'b0;
            par_en_r   <= 1'b0;
            par_typ_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!rx_s) begin
                        par_en_r   <= par_en_rx;
                        par_typ_r  <= par_typ_rx;
                        par_flag_r <= 1'b0;
                        bit_cnt_r  <= '0;
                    end
                end
                ST_DATA: begin
                    if (sample_done_s) begin
                        shift_r <= {majority_s, shift_r[DATA_WIDTH-1:1]};
                    end
                    if (bit_end_s && (bit_cnt_r != LAST_BIT)) begin
                        bit_cnt_r <= bit_cnt_r + BIT_ONE;
                    end
                end
                ST_PARITY: begin
                    if (sample_done_s) begin
                        par_flag_r <= majority_s != ((^shift_r) ^ par_typ_r);
                    end
                end
                default: begin
                    bit_cnt_r <= bit_cnt_r;
                end
            endcase
        end
    end

    // Registered outputs: strobes one clock after the stop decision, byte held until next good frame
    always_ff @(posedge clk_rx or posedge rst_rx) begin
        if (rst_rx) begin
            p_data_r  <= '0;
            valid_r   <= 1'b0;
            par_err_r <= 1'b0;
            stp_err_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            if (valid_next) begin
                p_data_r <= shift_r;
            end
            valid_r   <= valid_next;
            par_err_r <= par_err_next;
            stp_err_r <= stp_err_next;
            busy_r    <= state_next != ST_IDLE;
        end
    end

    assign p_data_rx     = p_data_r;
    assign data_valid_rx = valid_r;
    assign par_err_rx    = par_err_r;
    assign stp_err_rx    = stp_err_r;
    assign busy_rx       = busy_r;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed self-checking bench for uart_rx_fsm (PRESCALE=8, 8 data bits).
// Inputs change on falling edges; outputs are observed on falling edges.
module tb_uart_rx_fsm;
    import uart_pkg::*;

    localparam int P = 8;
`ifdef UART_RX_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk_rx = 1'b0;
    logic       rst_rx = 1'b1;
    logic       rx_in_rx = 1'b1;
    logic       par_en_rx = 1'b0;
    logic       par_typ_rx = 1'b0;
    logic [7:0] p_data_rx;
    logic       data_valid_rx;
    logic       par_err_rx;
    logic       stp_err_rx;
    logic       busy_rx;

    int cyc = 0;
    int valid_cnt = 0;
    int perr_cnt = 0;
    int serr_cnt = 0;
    int last_valid_cyc = 0;
    logic [7:0] last_data = 8'h00;
    int pass_cnt = 0;
    int chk_cnt = 0;

    uart_rx_fsm #(.PRESCALE(P), .DATA_WIDTH(8)) dut (
        .clk_rx       (clk_rx),
        .rst_rx       (rst_rx),
        .rx_in_rx     (rx_in_rx),
        .par_en_rx    (par_en_rx),
        .par_typ_rx   (par_typ_rx),
        .p_data_rx    (p_data_rx),
        .data_valid_rx(data_valid_rx),
        .par_err_rx   (par_err_rx),
        .stp_err_rx   (stp_err_rx),
        .busy_rx      (busy_rx)
    );

    always #5 clk_rx = ~clk_rx;

    always @(posedge clk_rx) cyc <= cyc + 1;

    // Strobe monitor: every high cycle of a strobe counts, so a stretched pulse shows up as an extra count
    always @(negedge clk_rx) begin
        if (data_valid_rx) begin
            valid_cnt      <= valid_cnt + 1;
            last_data      <= p_data_rx;
            last_valid_cyc <= cyc;
        end
        if (par_err_rx) perr_cnt <= perr_cnt + 1;
        if (stp_err_rx) serr_cnt <= serr_cnt + 1;
    end

    task automatic hold_line(input logic b, input int n);
        rx_in_rx = b;
        repeat (n) @(negedge clk_rx);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic pen, input logic ptyp,
                              input logic bad_par, input logic stop_bit, input int stop_len,
                              output int t0);
        par_en_rx  = pen;
        par_typ_rx = ptyp;
        t0 = cyc;
        hold_line(1'b0, P);
        for (int i = 0; i < 8; i++) hold_line(data[i], P);
        if (pen) hold_line((^data) ^ ptyp ^ bad_par, P);
        hold_line(stop_bit, stop_len);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_rx);
        chk_cnt++; if (p_data_rx !== 8'h00) $display("FAIL reset_data got %h exp 00", p_data_rx); else pass_cnt++;
        chk_cnt++; if ({data_valid_rx, par_err_rx, stp_err_rx, busy_rx} !== 4'b0000)
            $display("FAIL reset_flags got %b exp 0000", {data_valid_rx, par_err_rx, stp_err_rx, busy_rx}); else pass_cnt++;
        rst_rx = 1'b0;
        hold_line(1'b1, 4);
        chk_cnt++; if (valid_cnt + perr_cnt + serr_cnt !== 0)
            $display("FAIL reset_release_strobes got %0d exp 0", valid_cnt + perr_cnt + serr_cnt); else pass_cnt++;
    endtask

    task automatic test_even_parity();
        int t0;
        send_frame(8'hA5, 1'b1, PAR_EVEN, 1'b0, 1'b1, P, t0);
        hold_line(1'b1, 6);
        chk_cnt++; if (p_data_rx !== 8'hA5) $display("FAIL even_data got %h exp a5", p_data_rx); else pass_cnt++;
        chk_cnt++; if (valid_cnt !== 1) $display("FAIL even_valid_cnt got %0d exp 1", valid_cnt); else pass_cnt++;
        chk_cnt++; if (perr_cnt + serr_cnt !== 0) $display("FAIL even_err_cnt got %0d exp 0", perr_cnt + serr_cnt); else pass_cnt++;
        chk_cnt++; if (busy_rx !== 1'b0) $display("FAIL even_busy got %b exp 0", busy_rx); else pass_cnt++;
        chk_cnt++; if (last_valid_cyc - t0 !== 86 + LAT)
            $display("FAIL even_latency got %0d exp %0d", last_valid_cyc - t0, 86 + LAT); else pass_cnt++;
    endtask

    task automatic test_odd_parity_error();
        int t0;
        int v0;
        v0 = valid_cnt;
        send_frame(8'h3C, 1'b1, PAR_ODD, 1'b1, 1'b1, P, t0);
        hold_line(1'b1, 6);
        chk_cnt++; if (perr_cnt !== 1) $display("FAIL odd_perr_cnt got %0d exp 1", perr_cnt); else pass_cnt++;
        chk_cnt++; if (valid_cnt !== v0) $display("FAIL odd_no_valid got %0d exp %0d", valid_cnt, v0); else pass_cnt++;
        chk_cnt++; if (p_data_rx !== 8'hA5) $display("FAIL odd_data_hold got %h exp a5", p_data_rx); else pass_cnt++;
        chk_cnt++; if (serr_cnt !== 0) $display("FAIL odd_serr got %0d exp 0", serr_cnt); else pass_cnt++;
    endtask

    task automatic test_stop_break();
        int t0;
        int v0;
        v0 = valid_cnt;
        send_frame(8'h81, 1'b0, PAR_EVEN, 1'b0, 1'b0, P, t0);
        hold_line(1'b0, 40);
        chk_cnt++; if (serr_cnt !== 1) $display("FAIL break_serr_cnt got %0d exp 1", serr_cnt); else pass_cnt++;
        chk_cnt++; if (busy_rx !== 1'b1) $display("FAIL break_busy_low_line got %b exp 1", busy_rx); else pass_cnt++;
        hold_line(1'b1, 3 + LAT);
        chk_cnt++; if (busy_rx !== 1'b0) $display("FAIL break_busy_release got %b exp 0", busy_rx); else pass_cnt++;
        chk_cnt++; if (valid_cnt !== v0 || perr_cnt !== 1)
            $display("FAIL break_other_strobes got v=%0d p=%0d exp v=%0d p=1", valid_cnt, perr_cnt, v0); else pass_cnt++;
        hold_line(1'b1, 4);
    endtask

    task automatic test_glitch();
        int t0;
        int v0;
        v0 = valid_cnt;
        hold_line(1'b0, 2);
        hold_line(1'b1, 3 + LAT);
        chk_cnt++; if (busy_rx !== 1'b1) $display("FAIL glitch_busy_edge4 got %b exp 1", busy_rx); else pass_cnt++;
        @(negedge clk_rx);
        chk_cnt++; if (busy_rx !== 1'b0) $display("FAIL glitch_busy_edge5 got %b exp 0", busy_rx); else pass_cnt++;
        hold_line(1'b1, 4);
        chk_cnt++; if (valid_cnt !== v0 || perr_cnt !== 1 || serr_cnt !== 1)
            $display("FAIL glitch_no_strobe got v=%0d p=%0d s=%0d", valid_cnt, perr_cnt, serr_cnt); else pass_cnt++;
        send_frame(8'h55, 1'b0, PAR_EVEN, 1'b0, 1'b1, P, t0);
        hold_line(1'b1, 6);
        chk_cnt++; if (p_data_rx !== 8'h55 || valid_cnt !== v0 + 1)
            $display("FAIL glitch_next_frame got %h/%0d exp 55/%0d", p_data_rx, valid_cnt, v0 + 1); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int t0;
        int t1;
        int v0;
        v0 = valid_cnt;
        send_frame(8'h12, 1'b0, PAR_EVEN, 1'b0, 1'b1, P / 2 + 5, t0);
        chk_cnt++; if (last_data !== 8'h12 || valid_cnt !== v0 + 1)
            $display("FAIL b2b_first got %h/%0d exp 12/%0d", last_data, valid_cnt, v0 + 1); else pass_cnt++;
        send_frame(8'hEF, 1'b0, PAR_EVEN, 1'b0, 1'b1, P, t1);
        hold_line(1'b1, 6);
        chk_cnt++; if (last_data !== 8'hEF || valid_cnt !== v0 + 2)
            $display("FAIL b2b_second got %h/%0d exp ef/%0d", last_data, valid_cnt, v0 + 2); else pass_cnt++;
        chk_cnt++; if (last_valid_cyc - t1 !== 78 + LAT)
            $display("FAIL b2b_latency got %0d exp %0d", last_valid_cyc - t1, 78 + LAT); else pass_cnt++;
    endtask

    task automatic test_mid_frame_reset();
        int t0;
        int v0;
        logic [7:0] d;
        d = 8'h5A;
        v0 = valid_cnt;
        par_en_rx = 1'b0;
        hold_line(1'b0, P);
        for (int i = 0; i < 3; i++) hold_line(d[i], P);
        hold_line(d[3], 4);
        rst_rx = 1'b1;
        #1;
        chk_cnt++; if (p_data_rx !== 8'h00) $display("FAIL rst_mid_data got %h exp 00", p_data_rx); else pass_cnt++;
        chk_cnt++; if ({data_valid_rx, par_err_rx, stp_err_rx, busy_rx} !== 4'b0000)
            $display("FAIL rst_mid_flags got %b exp 0000", {data_valid_rx, par_err_rx, stp_err_rx, busy_rx}); else pass_cnt++;
        hold_line(1'b1, 2);
        rst_rx = 1'b0;
        hold_line(1'b1, 4);
        chk_cnt++; if (valid_cnt !== v0 || perr_cnt !== 1 || serr_cnt !== 1)
            $display("FAIL rst_mid_no_strobe got v=%0d p=%0d s=%0d", valid_cnt, perr_cnt, serr_cnt); else pass_cnt++;
        send_frame(8'h7E, 1'b0, PAR_EVEN, 1'b0, 1'b1, P, t0);
        hold_line(1'b1, 6);
        chk_cnt++; if (p_data_rx !== 8'h7E || valid_cnt !== v0 + 1)
            $display("FAIL rst_next_frame got %h/%0d exp 7e/%0d", p_data_rx, valid_cnt, v0 + 1); else pass_cnt++;
        chk_cnt++; if (last_valid_cyc - t0 !== 78 + LAT)
            $display("FAIL rst_next_latency got %0d exp %0d", last_valid_cyc - t0, 78 + LAT); else pass_cnt++;
    endtask

    initial begin
        @(negedge clk_rx);
        test_reset();
        test_even_parity();
        test_odd_parity_error();
        test_stop_break();
        test_glitch();
        test_back_to_back();
        test_mid_frame_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
